// File: rtl/motor_drive_sequencer_if.sv
// Command/status bundle between the switch decode,
// the drive sequencer and the L298 bridge pins.
interface motor_drive_sequencer_if #(
  parameter int DUTY_W = 12
);
  logic              req_en;
  logic [DUTY_W-1:0] req_duty;
  logic              req_dir;
  logic              oc_a;
  logic              oc_b;
  logic              fault_clr;
  logic [DUTY_W-1:0] duty;
  logic              in1;
  logic              in2;
  logic              in3;
  logic              in4;
  logic              fault;
  logic [2:0]        state;
  logic              busy;

  modport master (
    output req_en, req_duty, req_dir,
    output oc_a, oc_b, fault_clr,
    input  duty, in1, in2, in3, in4,
    input  fault, state, busy
  );

  modport slave (
    input  req_en, req_duty, req_dir,
    input  oc_a, oc_b, fault_clr,
    output duty, in1, in2, in3, in4,
    output fault, state, busy
  );
endinterface

// File: rtl/motor_drive_sequencer.sv
// Slew-limited duty sequencer for the dual L298 bridge:
// ramps, dead-time on reversal, overcurrent fault latch.
module motor_drive_sequencer #(
  parameter int PWM_PERIOD  = 2500,
  parameter int DUTY_W      = 12,
  parameter int STEP        = 25,
  parameter int STEP_CYCLES = 2500,
  parameter int DEAD_CYCLES = 250000,
  parameter int OC_FILT     = 2499
) (
  input  logic clk,
  input  logic rst_n,
  motor_drive_sequencer_if.slave bus
);

  localparam int TW = (STEP_CYCLES > 1) ?
                      $clog2(STEP_CYCLES) : 1;
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int OW = $clog2(OC_FILT + 1);

  localparam logic [DUTY_W-1:0] PWM_MAX =
    DUTY_W'(PWM_PERIOD);
  localparam logic [DUTY_W-1:0] STEP_V =
    DUTY_W'(STEP);
  localparam logic [TW-1:0] TICK_LAST =
    TW'(STEP_CYCLES - 1);
  localparam logic [DW-1:0] DEAD_LAST =
    DW'(DEAD_CYCLES - 1);
  localparam logic [OW-1:0] OC_MAX =
    OW'(OC_FILT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RAMP    = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_RAMP_DN = 3'd3;
  localparam logic [2:0] S_DEAD    = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  logic [2:0]        st;
  logic              dir;
  logic [DUTY_W-1:0] duty_q;
  logic [TW-1:0]     tick_cnt;
  logic [DW-1:0]     dead_cnt;
  logic [OW-1:0]     oc_a_cnt;
  logic [OW-1:0]     oc_b_cnt;

  logic [DUTY_W-1:0] clamped;
  logic [DUTY_W-1:0] tgt;
  logic [DUTY_W-1:0] diff;
  logic [DUTY_W-1:0] up_stp;
  logic [DUTY_W-1:0] dn_stp;
  logic              tick;
  logic              stop;
  logic              oc_trip;
  logic              drive;

  // Clamped target and the per-tick step sizes
  always_comb begin
    clamped = (bus.req_duty > PWM_MAX) ?
              PWM_MAX : bus.req_duty;
    tgt     = bus.req_en ? clamped : '0;
    diff    = (tgt >= duty_q) ?
              (tgt - duty_q) : (duty_q - tgt);
    up_stp  = (diff < STEP_V) ? diff : STEP_V;
    dn_stp  = (duty_q < STEP_V) ? duty_q : STEP_V;
    tick    = (tick_cnt == TICK_LAST);
    stop    = (bus.req_dir != dir) || (tgt == '0);
    oc_trip = (oc_a_cnt == OC_MAX) ||
              (oc_b_cnt == OC_MAX);
  end

  // Saturating run-length counters on both sense inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc_a_cnt <= '0;
      oc_b_cnt <= '0;
    end else begin
      if (!bus.oc_a)
        oc_a_cnt <= '0;
      else if (oc_a_cnt != OC_MAX)
        oc_a_cnt <= oc_a_cnt + 1'b1;
      if (!bus.oc_b)
        oc_b_cnt <= '0;
      else if (oc_b_cnt != OC_MAX)
        oc_b_cnt <= oc_b_cnt + 1'b1;
    end
  end

  // Sequencer: ramp, hold, ramp-down, dead-time, fault
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      dir      <= 1'b1;
      duty_q   <= '0;
      tick_cnt <= '0;
      dead_cnt <= '0;
    end else if (oc_trip) begin
      st     <= S_FAULT;
      duty_q <= '0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (tgt != '0) begin
            dir      <= bus.req_dir;
            st       <= S_RAMP;
            tick_cnt <= '0;
          end
        end
        S_RAMP: begin
          if (stop) begin
            st       <= S_RAMP_DN;
            tick_cnt <= '0;
          end else if (duty_q == tgt) begin
            st <= S_HOLD;
          end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick)
              duty_q <= (tgt > duty_q) ?
                        duty_q + up_stp :
                        duty_q - up_stp;
          end
        end
        S_HOLD: begin
          if (stop) begin
            st       <= S_RAMP_DN;
            tick_cnt <= '0;
          end else if (tgt != duty_q) begin
            st       <= S_RAMP;
            tick_cnt <= '0;
          end
        end
        S_RAMP_DN: begin
          if (duty_q == '0) begin
            st       <= S_DEAD;
            dead_cnt <= DEAD_LAST;
          end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick)
              duty_q <= duty_q - dn_stp;
          end
        end
        S_DEAD: begin
          if (dead_cnt == '0)
            st <= S_IDLE;
          else
            dead_cnt <= dead_cnt - 1'b1;
        end
        S_FAULT: begin
          if (bus.fault_clr && !bus.oc_a && !bus.oc_b) begin
            st       <= S_DEAD;
            dead_cnt <= DEAD_LAST;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  // Bridge pins coast outside the driving states
  always_comb begin
    drive     = (st == S_RAMP) || (st == S_HOLD) ||
                (st == S_RAMP_DN);
    bus.in1   = drive & dir;
    bus.in2   = drive & ~dir;
    bus.in3   = drive & ~dir;
    bus.in4   = drive & dir;
    bus.duty  = duty_q;
    bus.state = st;
    bus.fault = (st == S_FAULT);
    bus.busy  = (st == S_RAMP) || (st == S_RAMP_DN) ||
                (st == S_DEAD);
  end

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Scoreboard bench for motor_drive_sequencer with
// short tick, dead and filter lengths.
module tb_motor_drive_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_q[$];
  int   last;

  motor_drive_sequencer_if #(.DUTY_W(12)) bus ();

  motor_drive_sequencer #(
    .PWM_PERIOD (2500),
    .DUTY_W     (12),
    .STEP       (25),
    .STEP_CYCLES(4),
    .DEAD_CYCLES(10),
    .OC_FILT    (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d",
               tag, got, want);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int pins();
    return {28'd0, bus.in1, bus.in2, bus.in3, bus.in4};
  endfunction

  task automatic push_ramp(int from, int to);
    int v;
    int d;
    int s;
    v = from;
    while (v != to) begin
      d = (to > v) ? to - v : v - to;
      s = (d < 25) ? d : 25;
      v = (to > v) ? v + s : v - s;
      exp_q.push_back(v);
    end
  endtask

  task automatic wait_q(int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("q_drain", exp_q.size(), 0);
  endtask

  task automatic wait_state(int s, int max, string tag);
    int n;
    n = 0;
    while (int'(bus.state) != s && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(bus.state), s);
  endtask

  task automatic dead_len(string tag);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (int'(bus.state) == 4 && n < 50) begin
      if (pins() != 0) bad++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_len"}, n, 10);
    chk({tag, "_pins"}, bad, 0);
    chk({tag, "_idle"}, int'(bus.state), 0);
  endtask

  // Duty monitor: every change is matched to the scoreboard
  initial begin
    @(posedge rst_n);
    last = int'(bus.duty);
    forever begin
      @(posedge clk);
      #1;
      if (int'(bus.duty) != last) begin
        last = int'(bus.duty);
        if (exp_q.size() == 0)
          chk("duty_unexp", last, -1);
        else
          chk("duty", last, exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.req_en    = 1'b0;
    bus.req_duty  = '0;
    bus.req_dir   = 1'b0;
    bus.oc_a      = 1'b0;
    bus.oc_b      = 1'b0;
    bus.fault_clr = 1'b0;
    cyc(3);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_duty", int'(bus.duty), 0);
    chk("rst_pins", pins(), 0);
    chk("rst_fault", int'(bus.fault), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;

    // forward ramp to 100
    cyc(1);
    bus.req_en   = 1'b1;
    bus.req_duty = 12'd100;
    bus.req_dir  = 1'b1;
    push_ramp(0, 100);
    cyc(1);
    chk("s1_ramp", int'(bus.state), 1);
    chk("s1_pins", pins(), 4'b1001);
    chk("s1_busy", int'(bus.busy), 1);
    wait_q(40);
    wait_state(2, 10, "s1_hold");

    // reversal
    bus.req_dir = 1'b0;
    push_ramp(100, 0);
    cyc(1);
    chk("s2_rdn", int'(bus.state), 3);
    chk("s2_rdn_pins", pins(), 4'b1001);
    wait_q(40);
    wait_state(4, 5, "s2_dead");
    push_ramp(0, 100);
    dead_len("s2_dead");
    cyc(1);
    chk("s2_ramp", int'(bus.state), 1);
    chk("s2_pins", pins(), 4'b0110);
    wait_q(40);
    wait_state(2, 10, "s2_hold");

    // clamp to PWM_PERIOD and small step down
    bus.req_duty = 12'd4000;
    push_ramp(100, 2500);
    wait_q(600);
    wait_state(2, 10, "s3_hold_max");
    chk("s3_duty_max", int'(bus.duty), 2500);
    bus.req_duty = 12'd2490;
    push_ramp(2500, 2490);
    wait_q(20);
    wait_state(2, 10, "s3_hold_2490");
    bus.req_duty = 12'd100;
    push_ramp(2490, 100);
    wait_q(600);
    wait_state(2, 10, "s3_hold_100");

    // overcurrent filter
    bus.oc_a = 1'b1;
    cyc(7);
    bus.oc_a = 1'b0;
    cyc(2);
    chk("s4_no_fault", int'(bus.fault), 0);
    chk("s4_still_hold", int'(bus.state), 2);
    exp_q.push_back(0);
    bus.oc_b = 1'b1;
    cyc(8);
    chk("s4_pre_trip", int'(bus.fault), 0);
    bus.oc_b = 1'b0;
    cyc(1);
    chk("s4_fault", int'(bus.fault), 1);
    chk("s4_state", int'(bus.state), 5);
    chk("s4_duty", int'(bus.duty), 0);
    chk("s4_pins", pins(), 0);

    // fault clear
    bus.oc_b      = 1'b1;
    bus.fault_clr = 1'b1;
    cyc(2);
    chk("s5_held", int'(bus.state), 5);
    chk("s5_held_f", int'(bus.fault), 1);
    bus.oc_b      = 1'b0;
    bus.fault_clr = 1'b0;
    cyc(1);
    bus.fault_clr = 1'b1;
    cyc(1);
    bus.fault_clr = 1'b0;
    chk("s5_dead", int'(bus.state), 4);
    chk("s5_fault_off", int'(bus.fault), 0);
    push_ramp(0, 100);
    dead_len("s5_dead");
    cyc(1);
    chk("s5_ramp", int'(bus.state), 1);
    chk("s5_pins", pins(), 4'b0110);
    wait_q(40);
    wait_state(2, 10, "s5_hold");

    // stop, then reset mid-ramp
    bus.req_en = 1'b0;
    push_ramp(100, 0);
    wait_q(40);
    wait_state(0, 30, "s6_idle");
    bus.req_en  = 1'b1;
    bus.req_dir = 1'b1;
    push_ramp(0, 50);
    wait_q(30);
    chk("s6_mid", int'(bus.duty), 50);
    exp_q.push_back(0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_duty", int'(bus.duty), 0);
    chk("s6_rst_pins", pins(), 0);
    chk("s6_rst_state", int'(bus.state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_ramp(0, 100);
    cyc(1);
    chk("s6_ramp", int'(bus.state), 1);
    chk("s6_pins", pins(), 4'b1001);
    wait_q(40);
    wait_state(2, 10, "s6_hold");
    chk("q_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/motor_drive_sequencer.md
Name: motor_drive_sequencer

Overview:
Controller between the switch/command decode and the PWM generator for the dual L298 motor drive. It converts a requested duty and direction into a slew-limited pulse_width. Direction reversals are sequenced as ramp-down, dead-time with bridge coasting, direction swap, then ramp-up. It also filters both current-sense inputs and latches a fault that forces the bridge off until cleared.

Parameters:
PWM_PERIOD  2500    PWM counts per carrier period; duty clamp ceiling
DUTY_W      12      width of duty values
STEP        25      maximum duty change per ramp tick
STEP_CYCLES 2500    clk cycles between ramp ticks
DEAD_CYCLES 250000  coast time after duty reaches 0 (2.5 ms at 100 MHz)
OC_FILT     2499    consecutive high sense cycles that declare overcurrent

Ports:
clk        in   1       100 MHz system clock
rst_n      in   1       asynchronous active-low reset
req_en     in   1       1 = run at req_duty; 0 = stop request
req_duty   in   DUTY_W  requested pulse width in PWM counts
req_dir    in   1       1 = forward, 0 = reverse
oc_a       in   1       current-sense A, high = over limit (pre-synchronised)
oc_b       in   1       current-sense B, high = over limit
fault_clr  in   1       level; clears a latched fault
duty       out  DUTY_W  pulse_width to the PWM generator (both motors)
in1,in2    out  1       motor A direction pins
in3,in4    out  1       motor B direction pins
fault      out  1       latched overcurrent
state      out  3       IDLE=0, RAMP=1, HOLD=2, RAMP_DN=3, DEAD=4, FAULT=5
busy       out  1       1 in RAMP, RAMP_DN, DEAD

Behaviour:
- One clock and one reset: clk, with rst_n asynchronous and active-low. All state is reset asynchronously.
- Reset values: duty=0, all in* pins=0, fault=0, state=IDLE, active_dir=1, all counters=0.
- Target: tgt = req_en ? min(req_duty, PWM_PERIOD) : 0. This is evaluated combinationally every cycle.
- Pins: in1=active_dir, in2=~active_dir, in3=~active_dir, in4=active_dir, only in RAMP/HOLD/RAMP_DN. In IDLE, DEAD and FAULT all four pins are 0 (coast).
- Tick counter: cleared on entry to RAMP or RAMP_DN. It counts 0..STEP_CYCLES-1 and wraps. The tick is asserted in the cycle the count equals STEP_CYCLES-1. duty changes on the clock edge ending a tick cycle.
- IDLE: if tgt>0, latch active_dir<=req_dir and go to RAMP next cycle.
- RAMP:
  - If req_dir!=active_dir or tgt==0, go to RAMP_DN immediately. No duty change occurs that cycle.
  - Otherwise, on each tick, duty moves toward tgt by min(STEP, |tgt-duty|), up or down.
  - When duty==tgt, go to HOLD.
- HOLD:
  - If req_dir!=active_dir or tgt==0, go to RAMP_DN.
  - Otherwise, if tgt!=duty, go to RAMP.
- RAMP_DN:
  - On each tick, duty -= min(STEP, duty).
  - The request is ignored until the sequence completes; there is no abort back to RAMP.
  - When duty==0, go to DEAD and load the dead counter.
- DEAD: count DEAD_CYCLES cycles, then go to IDLE. IDLE re-evaluates the request, which re-latches the direction.
- Overcurrent filter:
  - Each channel has a saturating counter that increments while its sense input is high and clears to 0 on any low cycle.
  - Reaching OC_FILT in either counter raises oc_trip.
  - If both channels reach OC_FILT simultaneously, the result is a single trip.
- FAULT:
  - oc_trip has priority over all other transitions from every state. On the next edge: state=FAULT, duty=0 (no ramp), pins=0, fault=1.
  - Exit requires fault_clr=1 and oc_a=0 and oc_b=0 in the same cycle. The next state is DEAD, and fault returns to 0 on that edge.
  - A fault_clr pulse while a sense input is still high has no effect.
- Arithmetic: all duty math is unsigned DUTY_W. The min() terms prevent underflow and overshoot. duty never exceeds PWM_PERIOD.
- Simultaneous events: a direction change and a tick in the same RAMP cycle both arrive; RAMP_DN wins and duty is unchanged that cycle.
- Reset mid-ramp: duty and pins drop to 0 immediately, asynchronously.

Test Plan:
All scenarios use sim params STEP=25, STEP_CYCLES=4, DEAD_CYCLES=10, OC_FILT=8.
1. Reset, then req_en=1, req_duty=100, req_dir=1 -> state=RAMP after 1 cycle. in1..in4=1,0,0,1. duty steps 25,50,75,100 every 4 cycles, then state=HOLD.
2. From HOLD at 100, set req_dir=0 -> RAMP_DN. duty steps 75,50,25,0. Pins are 0 for exactly 10 DEAD cycles, then IDLE. Then RAMP with pins 0,1,1,0 and duty rising from 0.
3. req_duty=4000 -> duty saturates at 2500 and HOLD is entered. Later req_duty=2490 -> one tick of -10, then HOLD at 2490.
4. In HOLD at 100, oc_a high for 7 cycles then low -> no fault. oc_b high for 8 cycles -> next edge: fault=1, duty=0, pins=0, state=5.
5. In FAULT, assert fault_clr while oc_b is still high -> stays in FAULT. Drop oc_b, then assert fault_clr -> fault=0, DEAD for 10 cycles, IDLE, then ramp resumes toward tgt.
6. Deassert rst_n mid-ramp (duty=50) between clock edges -> duty=0, pins=0, state=IDLE immediately. After release, ramp restarts from 0.
